// File: rtl/macro_sequencer.sv
// macro_sequencer: passes motor control codes straight through and expands
// macro codes into timed step/gap manoeuvres with status outputs.
module macro_sequencer #(
   parameter int STEP_TICKS = 50,
   parameter int GAP_TICKS  = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] instruction,
   output logic [4:0] drive,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic [7:0] active_cmd,
   output logic [2:0] step_idx
);

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   localparam logic [7:0] WAVE   = 8'h1A;
   localparam logic [7:0] CIRCLE = 8'h19;
   localparam logic [7:0] PIUPIU = 8'h10;
   localparam logic [9:0] STEP_LAST = 10'(STEP_TICKS - 1);
   localparam logic [9:0] GAP_LAST =
      (GAP_TICKS > 0) ? 10'(GAP_TICKS - 1) : 10'd0;
   localparam bit HAS_GAP = (GAP_TICKS > 0);

   state_t     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic       armed_q, armed_d;
   logic [4:0] drive_q, drive_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       aborted_q, aborted_d;
   logic [7:0] active_q, active_d;
   logic [2:0] step_q, step_d;
   logic [2:0] step_nxt;
   logic       ctrl;

   function automatic logic is_ctrl(input logic [7:0] c);
      case (c)
         8'h08, 8'h04, 8'h02, 8'h01,
         8'h0A, 8'h09, 8'h06, 8'h05: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

   function automatic logic is_macro(input logic [7:0] c);
      return (c == WAVE) || (c == CIRCLE) || (c == PIUPIU);
   endfunction

   function automatic logic [4:0] step_code(
      input logic [7:0] m,
      input logic [2:0] idx
   );
      case (m)
         WAVE:    return idx[0] ? 5'h09 : 5'h0A;
         CIRCLE:  return 5'h09;
         PIUPIU:  return idx[0] ? 5'h04 : 5'h08;
         default: return 5'h00;
      endcase
   endfunction

   function automatic logic [2:0] last_step(input logic [7:0] m);
      return (m == CIRCLE) ? 3'd7 : 3'd3;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      armed_d   = armed_q;
      drive_d   = drive_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      active_d  = active_q;
      step_d    = step_q;
      step_nxt  = 3'(step_q + 3'd1);
      ctrl      = is_ctrl(instruction);

      // A byte with bit4 clear re-arms, so a held macro byte fires once
      if (!instruction[4]) armed_d = 1'b1;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            step_d = 3'd0;
            cnt_d  = 10'd0;
            if (ctrl) begin
               drive_d  = instruction[4:0];
               active_d = instruction;
            end else if (is_macro(instruction) && armed_q) begin
               state_d  = RUN;
               drive_d  = step_code(instruction, 3'd0);
               active_d = instruction;
               busy_d   = 1'b1;
               armed_d  = 1'b0;
            end else begin
               drive_d  = 5'd0;
               active_d = 8'd0;
            end
         end
         RUN, GAP: begin
            if (ctrl) begin
               state_d   = IDLE;
               drive_d   = instruction[4:0];
               active_d  = instruction;
               busy_d    = 1'b0;
               aborted_d = 1'b1;
               step_d    = 3'd0;
               cnt_d     = 10'd0;
            end else if (tick && state_q == RUN) begin
               if (cnt_q == STEP_LAST) begin
                  cnt_d = 10'd0;
                  if (step_q == last_step(active_q)) begin
                     state_d  = IDLE;
                     drive_d  = 5'd0;
                     busy_d   = 1'b0;
                     done_d   = 1'b1;
                     active_d = 8'd0;
                     step_d   = 3'd0;
                  end else if (HAS_GAP) begin
                     state_d = GAP;
                     drive_d = 5'd0;
                  end else begin
                     step_d  = step_nxt;
                     drive_d = step_code(active_q, step_nxt);
                  end
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end else if (tick) begin
               if (cnt_q == GAP_LAST) begin
                  state_d = RUN;
                  cnt_d   = 10'd0;
                  step_d  = step_nxt;
                  drive_d = step_code(active_q, step_nxt);
               end else begin
                  cnt_d = cnt_q + 10'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 10'd0;
         armed_q   <= 1'b1;
         drive_q   <= 5'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         active_q  <= 8'd0;
         step_q    <= 3'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         drive_q   <= drive_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         active_q  <= active_d;
         step_q    <= step_d;
      end
   end

   assign drive      = drive_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign aborted    = aborted_q;
   assign active_cmd = active_q;
   assign step_idx   = step_q;

endmodule

// File: tb/tb_macro_sequencer.sv
// tb_macro_sequencer: directed scenarios plus randomized traffic checked
// against a timeline-based reference model of the macro sequencer.
module tb_macro_sequencer;

   localparam int ST = 4;
   localparam int GT = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic [7:0] instruction = 8'd0;
   logic [4:0] drive;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [7:0] active_cmd;
   logic [2:0] step_idx;

   int total = 0;
   int bad = 0;

   macro_sequencer #(.STEP_TICKS(ST), .GAP_TICKS(GT)) dut (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .instruction(instruction),
      .drive(drive),
      .busy(busy),
      .done(done),
      .aborted(aborted),
      .active_cmd(active_cmd),
      .step_idx(step_idx)
   );

   always #5 clk = ~clk;

   // Reference model: a macro is a flat per-tick timeline of drive codes
   bit         m_run;
   bit         m_armed;
   int         m_el;
   logic [4:0] tl_code[$];
   int         tl_step[$];
   logic [4:0] m_drive;
   logic       m_busy, m_done, m_abort;
   logic [7:0] m_active;
   logic [2:0] m_step;

   function automatic bit ref_ctrl(input logic [7:0] c);
      return c inside {8'h08, 8'h04, 8'h02, 8'h01,
                       8'h0A, 8'h09, 8'h06, 8'h05};
   endfunction

   function automatic bit ref_macro(input logic [7:0] c);
      return c inside {8'h1A, 8'h19, 8'h10};
   endfunction

   task automatic build_tl(input logic [7:0] m);
      logic [4:0] tab[$];
      tl_code.delete();
      tl_step.delete();
      if (m == 8'h1A)
         tab = '{5'h0A, 5'h09, 5'h0A, 5'h09};
      else if (m == 8'h19)
         tab = '{5'h09, 5'h09, 5'h09, 5'h09,
                 5'h09, 5'h09, 5'h09, 5'h09};
      else
         tab = '{5'h08, 5'h04, 5'h08, 5'h04};
      foreach (tab[s]) begin
         if (s > 0)
            for (int k = 0; k < GT; k++) begin
               tl_code.push_back(5'h00);
               tl_step.push_back(s - 1);
            end
         for (int k = 0; k < ST; k++) begin
            tl_code.push_back(tab[s]);
            tl_step.push_back(s);
         end
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_armed = 1; m_el = 0;
      m_drive = 0; m_busy = 0; m_done = 0; m_abort = 0;
      m_active = 0; m_step = 0;
   endtask

   task automatic model_clock(input logic [7:0] ins, input logic tk);
      bit c, start;
      c = ref_ctrl(ins);
      start = 0;
      m_done = 0;
      m_abort = 0;
      if (m_run) begin
         if (c) begin
            m_run = 0; m_abort = 1;
            m_drive = ins[4:0]; m_active = ins;
         end else if (tk) begin
            m_el++;
            if (m_el == tl_code.size()) begin
               m_run = 0; m_done = 1;
               m_drive = 0; m_active = 0;
            end
         end
      end else begin
         if (c) begin
            m_drive = ins[4:0]; m_active = ins;
         end else if (ref_macro(ins) && m_armed) begin
            build_tl(ins);
            m_run = 1; m_el = 0; m_active = ins; start = 1;
         end else begin
            m_drive = 0; m_active = 0;
         end
      end
      if (!ins[4]) m_armed = 1;
      if (start) m_armed = 0;
      m_busy = m_run;
      if (m_run) begin
         m_drive = tl_code[m_el];
         m_step = 3'(tl_step[m_el]);
      end else begin
         m_step = 0;
      end
   endtask

   function automatic logic [18:0] act_v();
      return {drive, busy, done, aborted, active_cmd, step_idx};
   endfunction

   function automatic logic [18:0] exp_v();
      return {m_drive, m_busy, m_done, m_abort, m_active, m_step};
   endfunction

   task automatic cyc(input logic [7:0] ins, input logic tk);
      instruction = ins;
      tick = tk;
      @(posedge clk);
      model_clock(ins, tk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         instruction = 8'($urandom);
         tick = 1'($urandom);
         @(posedge clk);
         #1;
         total++;
         if (act_v() !== 19'd0) begin
            bad++;
            $display("FAIL reset_hold: got %h want 0", act_v());
         end
      end
      instruction = 8'd0;
      tick = 1'b0;
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(8'd0, 1'($urandom));
         total++;
         if (act_v() !== 19'd0 || act_v() !== exp_v()) begin
            bad++;
            $display("FAIL reset_release: got %h want 0", act_v());
         end
      end
   endtask

   task automatic test_passthrough();
      logic [7:0] seq[3];
      logic [4:0] want[3];
      seq = '{8'h09, 8'h0C, 8'h00};
      want = '{5'h09, 5'h00, 5'h00};
      for (int i = 0; i < 3; i++) begin
         cyc(seq[i], 1'b0);
         total++;
         if (drive !== want[i] || busy !== 1'b0
             || act_v() !== exp_v()) begin
            bad++;
            $display("FAIL passthrough[%0d]: got %h want %h",
                     i, act_v(), exp_v());
         end
      end
   endtask

   task automatic test_wave();
      int dones = 0;
      int maxstep = 0;
      for (int c = 0; c < 110; c++) begin
         cyc((c < 5) ? 8'h1A : 8'h00, (c % 3) == 2);
         if (done) dones++;
         if (busy && int'(step_idx) > maxstep) maxstep = int'(step_idx);
         total++;
         if (act_v() !== exp_v()) begin
            bad++;
            $display("FAIL wave_cycle%0d: got %h want %h",
                     c, act_v(), exp_v());
         end
      end
      total++;
      if (dones != 1 || maxstep != 3 || busy !== 1'b0) begin
         bad++;
         $display("FAIL wave_summary: got done=%0d step=%0d busy=%b want 1 3 0",
                  dones, maxstep, busy);
      end
   endtask

   task automatic test_retrigger();
      int dones = 0;
      int starts = 0;
      logic pb = 1'b0;
      for (int c = 0; c < 80; c++) begin
         cyc(8'h10, (c % 2) == 1);
         if (done) dones++;
         if (busy && !pb) starts++;
         pb = busy;
         total++;
         if (act_v() !== exp_v()) begin
            bad++;
            $display("FAIL retrig_cycle%0d: got %h want %h",
                     c, act_v(), exp_v());
         end
      end
      total++;
      if (dones != 1 || starts != 1 || drive !== 5'h00) begin
         bad++;
         $display("FAIL retrig_once: got done=%0d runs=%0d drv=%h want 1 1 00",
                  dones, starts, drive);
      end
      cyc(8'h00, 1'b0);
      cyc(8'h10, 1'b0);
      total++;
      if (busy !== 1'b1 || drive !== 5'h08 || act_v() !== exp_v()) begin
         bad++;
         $display("FAIL retrig_rearm: got %h want %h", act_v(), exp_v());
      end
      for (int c = 0; c < 40; c++) begin
         cyc(8'h00, 1'b1);
         total++;
         if (act_v() !== exp_v()) begin
            bad++;
            $display("FAIL retrig_second%0d: got %h want %h",
                     c, act_v(), exp_v());
         end
      end
   endtask

   task automatic test_preempt();
      int guard = 0;
      cyc(8'h19, 1'b1);
      while (!(m_run && m_el == 3 * (ST + GT) + ST - 1) && guard < 300) begin
         cyc(8'h00, 1'($urandom));
         guard++;
         total++;
         if (act_v() !== exp_v()) begin
            bad++;
            $display("FAIL preempt_run%0d: got %h want %h",
                     guard, act_v(), exp_v());
         end
      end
      total++;
      if (guard >= 300 || step_idx !== 3'd3) begin
         bad++;
         $display("FAIL preempt_reach: got step=%0d want 3", step_idx);
      end
      cyc(8'h04, 1'b1);
      total++;
      if (drive !== 5'h04 || busy !== 1'b0 || aborted !== 1'b1
          || done !== 1'b0 || active_cmd !== 8'h04
          || act_v() !== exp_v()) begin
         bad++;
         $display("FAIL preempt_hit: got %h want %h", act_v(), exp_v());
      end
      cyc(8'h00, 1'b0);
      total++;
      if (aborted !== 1'b0 || act_v() !== exp_v()) begin
         bad++;
         $display("FAIL preempt_after: got %h want %h", act_v(), exp_v());
      end
   endtask

   task automatic test_async_reset();
      int guard = 0;
      cyc(8'h1A, 1'b0);
      while (!(m_run && tl_code[m_el] == 5'h00) && guard < 100) begin
         cyc(8'h00, 1'b1);
         guard++;
      end
      total++;
      if (guard >= 100 || busy !== 1'b1 || drive !== 5'h00) begin
         bad++;
         $display("FAIL areset_gap: got %h want %h", act_v(), exp_v());
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (act_v() !== 19'd0) begin
         bad++;
         $display("FAIL areset_now: got %h want 0", act_v());
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      cyc(8'h1A, 1'b1);
      total++;
      if (busy !== 1'b1 || step_idx !== 3'd0 || drive !== 5'h0A
          || act_v() !== exp_v()) begin
         bad++;
         $display("FAIL areset_restart: got %h want %h", act_v(), exp_v());
      end
      for (int c = 0; c < 30; c++) begin
         cyc(8'h00, 1'b1);
         total++;
         if (act_v() !== exp_v()) begin
            bad++;
            $display("FAIL areset_run%0d: got %h want %h",
                     c, act_v(), exp_v());
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ctl[8];
      logic [7:0] mac[3];
      logic [7:0] v;
      int hold;
      int r;
      ctl = '{8'h08, 8'h04, 8'h02, 8'h01, 8'h0A, 8'h09, 8'h06, 8'h05};
      mac = '{8'h1A, 8'h19, 8'h10};
      for (int n = 0; n < 120; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3) v = 8'h00;
         else if (r < 5) v = ctl[$urandom_range(0, 7)];
         else if (r < 6) begin
            v = 8'($urandom);
            while (v == 0 || ref_ctrl(v) || ref_macro(v)) v = 8'($urandom);
         end else v = mac[$urandom_range(0, 2)];
         hold = int'($urandom_range(1, 40));
         for (int c = 0; c < hold; c++) begin
            cyc(v, ($urandom_range(0, 2) == 0));
            total++;
            if (act_v() !== exp_v() || (done && aborted)) begin
               bad++;
               $display("FAIL random%0d.%0d: got %h want %h",
                        n, c, act_v(), exp_v());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_passthrough();
      test_wave();
      test_retrigger();
      test_preempt();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
